// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the k580vt57 four-channel DMA controller.
package k580vt57_pkg;

   localparam int NCH = 4;

   typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4} state_t;

   localparam logic [3:0] REG_MODE   = 4'd8;
   localparam logic [3:0] REG_STATUS = 4'd8;

   localparam int MODE_ROT      = 4;
   localparam int MODE_EXTW     = 5;
   localparam int MODE_TCSTOP   = 6;
   localparam int MODE_AUTOLOAD = 7;

   localparam int STAT_UPD = 4;

   localparam logic [1:0] XFER_VERIFY = 2'b00;
   localparam logic [1:0] XFER_WRITE  = 2'b01;
   localparam logic [1:0] XFER_READ   = 2'b10;

   localparam logic [1:0] AUTOLOAD_CH = 2'd2;
   localparam logic [1:0] RELOAD_CH   = 2'd3;

   function automatic logic [1:0] ch_index(input logic [NCH-1:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < NCH; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/k580vt57_if.sv
// CPU register bus and system bus of the k580vt57; slave is the controller side.
interface k580vt57_if;
   import k580vt57_pkg::*;

   logic [3:0]     iaddr;
   logic [7:0]     idata;
   logic [7:0]     odata;
   logic           iwe_n;
   logic           ird_n;
   logic [NCH-1:0] drq;
   logic [NCH-1:0] dack;
   logic           hrq;
   logic           hlda;
   logic [15:0]    oaddr;
   logic           omemr_n;
   logic           omemw_n;
   logic           oior_n;
   logic           oiow_n;
   logic           tc;
   logic           mark;

   modport slave (
      input  iaddr, idata, iwe_n, ird_n, drq, hlda,
      output odata, dack, hrq, oaddr, omemr_n, omemw_n, oior_n, oiow_n, tc, mark
   );

   modport master (
      output iaddr, idata, iwe_n, ird_n, drq, hlda,
      input  odata, dack, hrq, oaddr, omemr_n, omemw_n, oior_n, oiow_n, tc, mark
   );

endinterface

// File: rtl/k580vt57_prio.sv
// Combinational 4-way request resolver; base names the highest-priority channel.
module k580vt57_prio
   import k580vt57_pkg::*;
(
   input  logic [NCH-1:0] req,
   input  logic [1:0]     base,
   output logic [NCH-1:0] gnt
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = base;
      for (int i = 0; i < NCH; i++) begin
         idx = base + 2'(i);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/k580vt57.sv
// Four-channel DMA controller (8257 equivalent): register file, bus FSM, channel update.
//
// state | meaning
// IDLE  | no enabled request, hrq low
// S0    | hrq high, waiting for hlda
// S1    | winner latched, dack and oaddr driven
// S2    | strobes start (extended write starts here too)
// S3    | all strobes for the transfer type active
// S4    | address/count update, TC/autoload handling, next-request decision
module k580vt57
   import k580vt57_pkg::*;
#(
   parameter int CH_N = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      ce,
   k580vt57_if.slave bus
);

   state_t         state, state_nx;
   logic [15:0]    addr_r [CH_N];
   logic [15:0]    cnt_r  [CH_N];
   logic [15:0]    addr_nx[CH_N];
   logic [15:0]    cnt_nx [CH_N];
   logic [7:0]     mode_r, mode_nx;
   logic [NCH-1:0] tcf_r, tcf_nx;
   logic           upd_r, upd_nx;
   logic           ff_r, ff_nx;
   logic           iwe_q, ird_q;
   logic [1:0]     cur_r, rot_r, base;
   logic [1:0]     wr_ch;
   logic           wr_stb, rd_stb;
   logic [NCH-1:0] req, gnt, cur_oh, stop_clr;
   logic [15:0]    cur_cnt;
   logic           in_xfer, tc_now, mark_now, reload, do_update;
   logic [15:0]    rd_word;
   logic [7:0]     stat;

   logic [NCH-1:0] dack_c;
   logic [15:0]    oaddr_c;
   logic           hrq_c, memr_c, memw_c, ior_c, iow_c;
   logic [7:0]     odata_c;

   assign wr_stb    = bus.iwe_n & ~iwe_q;
   assign rd_stb    = bus.ird_n & ~ird_q;
   assign wr_ch     = bus.iaddr[2:1];
   assign in_xfer   = (state == S1) || (state == S2) || (state == S3) || (state == S4);
   assign cur_cnt   = cnt_r[cur_r];
   assign cur_oh    = NCH'(1) << cur_r;
   assign tc_now    = in_xfer && (cur_cnt[13:0] == 14'd0);
   assign mark_now  = in_xfer && (cur_cnt[6:0] == 7'd0) && !tc_now;
   assign reload    = (state == S4) && tc_now && mode_r[MODE_AUTOLOAD] && (cur_r == AUTOLOAD_CH);
   assign stop_clr  = ((state == S4) && tc_now && mode_r[MODE_TCSTOP] && !reload) ? cur_oh : '0;
   assign req       = bus.drq & mode_r[NCH-1:0] & ~stop_clr;
   assign do_update = ce && (state == S4);

   // In S4 the next winner is chosen with the base that this transfer leaves behind.
   always_comb begin
      base = 2'd0;
      if (mode_r[MODE_ROT]) begin
         base = (state == S4) ? cur_r + 2'd1 : rot_r;
      end
   end

   k580vt57_prio u_prio (
      .req  (req),
      .base (base),
      .gnt  (gnt)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else if (ce) state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (|req) state_nx = S0;
         S0: begin
            if (!(|req)) state_nx = IDLE;
            else if (bus.hlda) state_nx = S1;
         end
         S1: state_nx = S2;
         S2: state_nx = S3;
         S3: state_nx = S4;
         S4: state_nx = ((|req) && bus.hlda) ? S1 : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      hrq_c   = (state != IDLE);
      dack_c  = in_xfer ? cur_oh : '0;
      oaddr_c = in_xfer ? addr_r[cur_r] : 16'h0000;
      memr_c  = 1'b1;
      memw_c  = 1'b1;
      ior_c   = 1'b1;
      iow_c   = 1'b1;
      if ((state == S2) || (state == S3)) begin
         case (cur_cnt[15:14])
            XFER_READ: begin
               memr_c = 1'b0;
               if ((state == S3) || mode_r[MODE_EXTW]) iow_c = 1'b0;
            end
            XFER_WRITE: begin
               ior_c = 1'b0;
               if ((state == S3) || mode_r[MODE_EXTW]) memw_c = 1'b0;
            end
            XFER_VERIFY: ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_r <= 2'd0;
         rot_r <= 2'd0;
      end else begin
         if (ce && (state_nx == S1)) cur_r <= ch_index(gnt);
         if (wr_stb && (bus.iaddr == REG_MODE)) rot_r <= 2'd0;
         else if (do_update && mode_r[MODE_ROT]) rot_r <= cur_r + 2'd1;
      end
   end

   // Register next-state: status clear, then S4 update, then CPU write so the CPU byte wins.
   always_comb begin
      for (int i = 0; i < CH_N; i++) begin
         addr_nx[i] = addr_r[i];
         cnt_nx[i]  = cnt_r[i];
      end
      mode_nx = mode_r;
      tcf_nx  = tcf_r;
      upd_nx  = upd_r;
      ff_nx   = ff_r;

      if (rd_stb) begin
         if (!bus.iaddr[3]) ff_nx = ~ff_r;
         else if (bus.iaddr == REG_STATUS) tcf_nx = '0;
      end

      if (do_update) begin
         for (int i = 0; i < CH_N; i++) begin
            if (2'(i) == cur_r) begin
               if (reload) begin
                  addr_nx[i] = addr_r[RELOAD_CH];
                  cnt_nx[i]  = cnt_r[RELOAD_CH];
               end else begin
                  addr_nx[i] = addr_r[i] + 16'd1;
                  cnt_nx[i]  = {cnt_r[i][15:14], cnt_r[i][13:0] - 14'd1};
               end
            end
         end
         if (tc_now) tcf_nx = tcf_nx | cur_oh;
         mode_nx[NCH-1:0] = mode_r[NCH-1:0] & ~stop_clr;
         if (cur_r == AUTOLOAD_CH) upd_nx = reload;
      end

      if (wr_stb && !bus.iaddr[3]) begin
         for (int i = 0; i < CH_N; i++) begin
            if ((2'(i) == wr_ch) ||
                (mode_r[MODE_AUTOLOAD] && (wr_ch == AUTOLOAD_CH) && (2'(i) == RELOAD_CH))) begin
               if (bus.iaddr[0]) begin
                  if (ff_r) cnt_nx[i][15:8] = bus.idata;
                  else      cnt_nx[i][7:0]  = bus.idata;
               end else begin
                  if (ff_r) addr_nx[i][15:8] = bus.idata;
                  else      addr_nx[i][7:0]  = bus.idata;
               end
            end
         end
         ff_nx = ~ff_r;
      end else if (wr_stb && (bus.iaddr == REG_MODE)) begin
         mode_nx = bus.idata;
         ff_nx   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH_N; i++) begin
            addr_r[i] <= 16'h0000;
            cnt_r[i]  <= 16'h0000;
         end
         mode_r <= 8'h00;
         tcf_r  <= '0;
         upd_r  <= 1'b0;
         ff_r   <= 1'b0;
         iwe_q  <= 1'b1;
         ird_q  <= 1'b1;
      end else begin
         for (int i = 0; i < CH_N; i++) begin
            addr_r[i] <= addr_nx[i];
            cnt_r[i]  <= cnt_nx[i];
         end
         mode_r <= mode_nx;
         tcf_r  <= tcf_nx;
         upd_r  <= upd_nx;
         ff_r   <= ff_nx;
         iwe_q  <= bus.iwe_n;
         ird_q  <= bus.ird_n;
      end
   end

   always_comb begin
      rd_word        = bus.iaddr[0] ? cnt_r[wr_ch] : addr_r[wr_ch];
      stat           = 8'h00;
      stat[NCH-1:0]  = tcf_r;
      stat[STAT_UPD] = upd_r;
      odata_c        = 8'h00;
      if (!bus.iaddr[3]) odata_c = ff_r ? rd_word[15:8] : rd_word[7:0];
      else if (bus.iaddr == REG_STATUS) odata_c = stat;
   end

   assign bus.odata   = odata_c;
   assign bus.hrq     = hrq_c;
   assign bus.dack    = dack_c;
   assign bus.oaddr   = oaddr_c;
   assign bus.omemr_n = memr_c;
   assign bus.omemw_n = memw_c;
   assign bus.oior_n  = ior_c;
   assign bus.oiow_n  = iow_c;
   assign bus.tc      = tc_now;
   assign bus.mark    = mark_now;

endmodule

// File: tb/tb_k580vt57.sv
// Directed bench for k580vt57: register access, transfer sequencing, priority, TC and autoload.
module tb_k580vt57;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce;
   logic       hlda_en;
   logic [7:0] d;
   logic [3:0] strb;
   int         n_run  = 0;
   int         n_fail = 0;

   localparam logic [1:0] T_VER = 2'b00;
   localparam logic [1:0] T_WR  = 2'b01;
   localparam logic [1:0] T_RD  = 2'b10;

   k580vt57_if bus();

   k580vt57 #(.CH_N(4)) dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.hlda = bus.hrq & hlda_en;
   assign strb     = {bus.omemr_n, bus.omemw_n, bus.oior_n, bus.oiow_n};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] v);
      bus.iaddr = a;
      bus.idata = v;
      bus.iwe_n = 1'b0;
      tick();
      bus.iwe_n = 1'b1;
      tick();
   endtask

   task automatic wr16(input logic [3:0] a, input logic [15:0] v);
      wr(a, v[7:0]);
      wr(a, v[15:8]);
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] v);
      bus.iaddr = a;
      bus.ird_n = 1'b0;
      tick();
      v = bus.odata;
      bus.ird_n = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Strobe vector {memr, memw, ior, iow} expected in phase ph of a transfer.
   function automatic logic [3:0] exp_strb(input logic [1:0] typ, input logic ext, input int ph);
      logic [3:0] s;
      s = 4'b1111;
      if (typ == T_RD) begin
         if (ph == 2) s = {1'b0, 1'b1, 1'b1, ~ext};
         if (ph == 3) s = 4'b0110;
      end else if (typ == T_WR) begin
         if (ph == 2) s = {1'b1, ~ext, 1'b0, 1'b1};
         if (ph == 3) s = 4'b1001;
      end
      return s;
   endfunction

   task automatic wait_s1(input string tag);
      int n;
      n = 0;
      while ((bus.dack == 4'b0000) && (n < 20)) begin
         tick();
         n++;
      end
      chk({tag, "_start"}, 32'(bus.dack != 4'b0000), 32'd1);
   endtask

   task automatic xfer(input string tag, input logic [15:0] ea, input logic [3:0] edack,
                       input logic etc, input logic emark, input logic [1:0] typ,
                       input logic ext, input logic [3:0] drop);
      wait_s1(tag);
      chk({tag, "_addr"}, bus.oaddr, ea);
      chk({tag, "_dack"}, bus.dack, edack);
      chk({tag, "_tc"}, bus.tc, etc);
      chk({tag, "_mark"}, bus.mark, emark);
      chk({tag, "_s1"}, strb, 4'b1111);
      bus.drq = bus.drq & ~drop;
      tick();
      chk({tag, "_s2"}, strb, exp_strb(typ, ext, 2));
      tick();
      chk({tag, "_s3"}, strb, exp_strb(typ, ext, 3));
      chk({tag, "_s3dack"}, bus.dack, edack);
      tick();
      chk({tag, "_s4"}, strb, 4'b1111);
      chk({tag, "_s4tc"}, bus.tc, etc);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      ce        = 1'b1;
      hlda_en   = 1'b1;
      bus.iaddr = 4'd0;
      bus.idata = 8'h00;
      bus.iwe_n = 1'b1;
      bus.ird_n = 1'b1;
      bus.drq   = 4'b0000;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      chk("rst_hrq", bus.hrq, 1'b0);
      chk("rst_dack", bus.dack, 4'b0000);
      chk("rst_oaddr", bus.oaddr, 16'h0000);
      chk("rst_strb", strb, 4'b1111);
      chk("rst_tc", bus.tc, 1'b0);
      chk("rst_mark", bus.mark, 1'b0);
      chk("rst_odata", bus.odata, 8'h00);

      // single read, 3 bytes from 1000h on channel 2
      wr(4'd8, 8'h04);
      wr16(4'd4, 16'h1000);
      wr16(4'd5, 16'h8002);
      rd(4'd4, d); chk("rb_addr_lo", d, 8'h00);
      rd(4'd4, d); chk("rb_addr_hi", d, 8'h10);
      rd(4'd5, d); chk("rb_cnt_lo", d, 8'h02);
      rd(4'd5, d); chk("rb_cnt_hi", d, 8'h80);
      ce = 1'b0;
      bus.drq = 4'b0100;
      repeat (3) tick();
      chk("ce_gate_hrq", bus.hrq, 1'b0);
      ce = 1'b1;
      tick();
      chk("lat_hrq", bus.hrq, 1'b1);
      chk("lat_s0_dack", bus.dack, 4'b0000);
      tick();
      chk("lat_dack", bus.dack, 4'b0100);
      xfer("rd1", 16'h1000, 4'b0100, 1'b0, 1'b0, T_RD, 1'b0, 4'b0000);
      xfer("rd2", 16'h1001, 4'b0100, 1'b0, 1'b0, T_RD, 1'b0, 4'b0000);
      xfer("rd3", 16'h1002, 4'b0100, 1'b1, 1'b0, T_RD, 1'b0, 4'b0100);
      chk("rd_end_hrq", bus.hrq, 1'b0);
      rd(4'd8, d); chk("rd_status1", d, 8'h04);
      rd(4'd8, d); chk("rd_status2", d, 8'h00);
      rd(4'd4, d); chk("rd_addr_after_lo", d, 8'h03);
      rd(4'd4, d); chk("rd_addr_after_hi", d, 8'h10);
      rd(4'd5, d); chk("rd_cnt_after_lo", d, 8'hFF);
      rd(4'd5, d); chk("rd_cnt_after_hi", d, 8'hBF);

      // fixed then rotating priority between channels 0 and 3
      do_reset();
      wr(4'd8, 8'h09);
      bus.drq = 4'b1001;
      xfer("fx1", 16'h0000, 4'b0001, 1'b1, 1'b0, T_VER, 1'b0, 4'b0000);
      xfer("fx2", 16'h0001, 4'b0001, 1'b0, 1'b0, T_VER, 1'b0, 4'b1001);
      chk("fx_end_hrq", bus.hrq, 1'b0);
      wr(4'd8, 8'h19);
      bus.drq = 4'b1001;
      xfer("rt1", 16'h0002, 4'b0001, 1'b0, 1'b0, T_VER, 1'b0, 4'b0000);
      xfer("rt2", 16'h0000, 4'b1000, 1'b1, 1'b0, T_VER, 1'b0, 4'b0000);
      xfer("rt3", 16'h0003, 4'b0001, 1'b0, 1'b0, T_VER, 1'b0, 4'b1001);
      chk("rt_end_hrq", bus.hrq, 1'b0);

      // autoload: channel 2 re-armed from channel 3 after its last byte
      do_reset();
      wr(4'd8, 8'h84);
      wr16(4'd4, 16'h2000);
      wr16(4'd5, 16'h4001);
      bus.drq = 4'b0100;
      xfer("al1", 16'h2000, 4'b0100, 1'b0, 1'b0, T_WR, 1'b0, 4'b0000);
      xfer("al2", 16'h2001, 4'b0100, 1'b1, 1'b0, T_WR, 1'b0, 4'b0000);
      bus.iaddr = 4'd8;
      #1;
      chk("al_status_upd", bus.odata, 8'h14);
      xfer("al3", 16'h2000, 4'b0100, 1'b0, 1'b0, T_WR, 1'b0, 4'b0100);
      rd(4'd8, d); chk("al_status_end", d, 8'h04);
      rd(4'd4, d); chk("al_addr_lo", d, 8'h01);
      rd(4'd4, d); chk("al_addr_hi", d, 8'h20);
      rd(4'd6, d); chk("al_ch3_lo", d, 8'h00);
      rd(4'd6, d); chk("al_ch3_hi", d, 8'h20);

      // TC-stop: channel disables itself after its only byte
      do_reset();
      wr(4'd8, 8'h44);
      wr16(4'd4, 16'h3000);
      wr16(4'd5, 16'h4000);
      bus.drq = 4'b0100;
      xfer("ts1", 16'h3000, 4'b0100, 1'b1, 1'b0, T_WR, 1'b0, 4'b0000);
      chk("ts_hrq_drop", bus.hrq, 1'b0);
      repeat (5) tick();
      chk("ts_hrq_ignored", bus.hrq, 1'b0);
      chk("ts_dack_ignored", bus.dack, 4'b0000);
      bus.drq = 4'b0000;

      // mark, address wrap, extended write, hlda dropped mid-transfer
      do_reset();
      wr(4'd8, 8'h24);
      wr16(4'd4, 16'hFFFF);
      wr16(4'd5, 16'h4080);
      bus.drq = 4'b0100;
      xfer("mw1", 16'hFFFF, 4'b0100, 1'b0, 1'b1, T_WR, 1'b1, 4'b0000);
      hlda_en = 1'b0;
      xfer("mw2", 16'h0000, 4'b0100, 1'b0, 1'b0, T_WR, 1'b1, 4'b0000);
      chk("mw_hlda_idle", bus.hrq, 1'b0);
      tick();
      chk("mw_rerequest", bus.hrq, 1'b1);
      tick();
      chk("mw_no_dack", bus.dack, 4'b0000);
      bus.drq = 4'b0000;
      hlda_en = 1'b1;
      repeat (2) tick();

      // reset while strobes are active in S2
      do_reset();
      wr(4'd8, 8'h04);
      wr16(4'd4, 16'h1234);
      wr16(4'd5, 16'h8005);
      bus.drq = 4'b0100;
      wait_s1("rs");
      tick();
      chk("rs_s2_strb", strb, 4'b0111);
      reset = 1'b1;
      tick();
      chk("rs_strb", strb, 4'b1111);
      chk("rs_hrq", bus.hrq, 1'b0);
      chk("rs_dack", bus.dack, 4'b0000);
      reset = 1'b0;
      repeat (2) tick();
      chk("rs_mode_cleared", bus.hrq, 1'b0);
      rd(4'd4, d); chk("rs_addr_lo", d, 8'h00);
      rd(4'd4, d); chk("rs_addr_hi", d, 8'h00);
      rd(4'd5, d); chk("rs_cnt_lo", d, 8'h00);
      bus.drq = 4'b0000;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
